// File: rtl/uart2wb_burst.sv
// uart2wb_burst: UART byte-stream to Wishbone burst master with bus/frame timeouts and status bytes.
// Define UART2WB_CHKSUM_EN to add a trailing two's-complement checksum to every frame and response.
module uart2wb_burst #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_BURST = 16,
  parameter int WB_TO = 1024,
  parameter int FRAME_TO = 65535
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_we_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i,
  output logic            rx_drop,
  output logic            busy
);
`ifdef UART2WB_CHKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int AB = AW / 8;
  localparam int DB = DW / 8;
  localparam int IW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam int WTW = $clog2(WB_TO + 1);
  localparam int FTW = $clog2(FRAME_TO + 1);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WB_REQ, WB_WAIT, TX_DATA, TX_STAT} state_t;
  state_t state;
  logic we, inc;
  logic [5:0] nm1;
  logic [AW-1:0] adr, adr_nx;
  logic [DW-1:0] sh, wrd;
  logic [DW-1:0] buf_mem [MAX_BURST];
  logic [3:0] bcnt;
  logic [6:0] widx;
  logic [7:0] stat, rsum, tsum;
  logic [WTW-1:0] wtmr;
  logic [FTW-1:0] ftmr;
  logic big, last_w, data_ph, sum_bad, buf_we;
  assign big = {1'b0, nm1} >= 7'(MAX_BURST);
  assign last_w = widx == {1'b0, nm1};
  assign data_ph = widx <= {1'b0, nm1};
  assign sum_bad = CK != 0 && (rsum + rx_data) != 8'h00;
  assign wrd = (sh << 8) | DW'(rx_data);
  assign adr_nx = inc ? adr + AW'(DB) : adr;
  assign buf_we = state == WDATA && rx_valid && data_ph && bcnt == 4'(DB - 1) && !big;
  assign wbm_adr_o = adr;
  assign wbm_sel_o = '1;
  assign busy = state != IDLE;
  always_ff @(posedge wb_clk_i) if (buf_we) buf_mem[widx[IW-1:0]] <= wrd;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      {we, inc, nm1} <= '0;
      adr <= '0;
      sh <= '0;
      bcnt <= '0;
      widx <= '0;
      stat <= '0;
      rsum <= '0;
      tsum <= '0;
      wtmr <= '0;
      ftmr <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      wbm_dat_o <= '0;
      {wbm_we_o, wbm_cyc_o, wbm_stb_o} <= '0;
      rx_drop <= 1'b0;
    end else begin
      rx_drop <= rx_valid && !(state inside {IDLE, ADDR, WDATA});
      case (state)
        IDLE: if (rx_valid) begin
          {we, inc, nm1} <= rx_data;
          rsum <= rx_data;
          bcnt <= '0;
          widx <= '0;
          ftmr <= '0;
          state <= ADDR;
        end
        ADDR, WDATA: if (rx_valid) begin
          rsum <= rsum + rx_data;
          ftmr <= '0;
          bcnt <= bcnt + 1'b1;
          if (state == ADDR) begin
            if (bcnt < 4'(AB)) adr <= (adr << 8) | AW'(rx_data);
            if (we && bcnt == 4'(AB - 1)) begin
              bcnt <= '0;
              state <= WDATA;
            end else if (!we && bcnt == 4'(AB - 1 + CK)) begin
              bcnt <= '0;
              stat <= big ? 8'hE2 : 8'hE4;
              state <= big || sum_bad ? TX_STAT : WB_REQ;
            end
          end else if (data_ph) begin
            sh <= wrd;
            if (bcnt == 4'(DB - 1)) begin
              bcnt <= '0;
              widx <= widx + 1'b1;
              if (last_w && CK == 0) begin
                widx <= '0;
                stat <= 8'hE2;
                state <= big ? TX_STAT : WB_REQ;
              end
            end
          end else begin
            // all words in: this byte is the frame checksum
            bcnt <= '0;
            widx <= '0;
            stat <= big ? 8'hE2 : 8'hE4;
            state <= big || sum_bad ? TX_STAT : WB_REQ;
          end
        end else if (ftmr == FTW'(FRAME_TO - 1)) state <= IDLE;
        else ftmr <= ftmr + 1'b1;
        WB_REQ: begin
          wbm_dat_o <= buf_mem[widx[IW-1:0]];
          wbm_we_o <= we;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wtmr <= '0;
          state <= WB_WAIT;
        end
        WB_WAIT: if (wbm_err_i || wbm_ack_i || wtmr == WTW'(WB_TO - 1)) begin
          {wbm_we_o, wbm_cyc_o, wbm_stb_o} <= '0;
          stat <= wbm_err_i ? 8'hE1 : wbm_ack_i ? 8'hA5 : 8'hE3;
          sh <= wbm_dat_i;
          tsum <= '0;
          if (wbm_ack_i && !wbm_err_i && !we) state <= TX_DATA;
          else if (wbm_ack_i && !wbm_err_i && !last_w) begin
            adr <= adr_nx;
            widx <= widx + 1'b1;
            state <= WB_REQ;
          end else state <= TX_STAT;
        end else wtmr <= wtmr + 1'b1;
        TX_DATA: if (!tx_valid) begin
          tx_valid <= 1'b1;
          tx_data <= bcnt == 4'(DB) ? 8'h00 - tsum : sh[DW-1 -: 8];
          sh <= sh << 8;
        end else if (tx_ready) begin
          tx_valid <= 1'b0;
          tsum <= tsum + tx_data;
          bcnt <= bcnt + 1'b1;
          if (bcnt == 4'(DB - 1 + CK)) begin
            bcnt <= '0;
            adr <= adr_nx;
            widx <= widx + 1'b1;
            state <= last_w ? TX_STAT : WB_REQ;
          end
        end
        TX_STAT: if (!tx_valid) begin
          tx_valid <= 1'b1;
          tx_data <= bcnt == 4'd0 ? stat : 8'h00 - stat;
        end else if (tx_ready) begin
          tx_valid <= 1'b0;
          bcnt <= bcnt + 1'b1;
          if (bcnt == 4'(CK)) begin
            bcnt <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
